// File: rtl/pic_pc_stack_unit_pkg.sv
// pic_pc_stack_unit_pkg: default geometry, vectors and PC command priority encoding for the PC/stack unit.
package pic_pc_stack_unit_pkg;
  localparam int PC_W_DEF       = 13;
  localparam int J_W_DEF        = 11;
  localparam int DEPTH_DEF      = 8;
  localparam int RST_VECTOR_DEF = 0;
  localparam int IRQ_VECTOR_DEF = 4;
  typedef enum logic [2:0] {
    CMD_NONE, CMD_INCR, CMD_PCL, CMD_JMP, CMD_CALL, CMD_RET, CMD_IRQ
  } cmd_e;
  function automatic cmd_e cmd_sel(input logic irq, input logic ret, input logic call,
                                   input logic jmp, input logic pcl, input logic incr);
    return irq ? CMD_IRQ : ret ? CMD_RET : call ? CMD_CALL :
           jmp ? CMD_JMP : pcl ? CMD_PCL : incr ? CMD_INCR : CMD_NONE;
  endfunction
endpackage

// File: rtl/pic_pc_stack_unit_return_stack.sv
// pic_pc_stack_unit_return_stack: circular return stack with saturating fill level.
// PIC_STACK_STATUS_EN adds sticky overflow/underflow flags with a clear input.
module pic_pc_stack_unit_return_stack #(
  parameter int PC_W  = 13,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_data,
  output logic [PC_W-1:0]            pop_data,
`ifdef PIC_STACK_STATUS_EN
  input  logic                       stk_flag_clr,
  output logic                       stk_ovf,
  output logic                       stk_unf,
`endif
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PC_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_level;
  logic [PTR_W-1:0] w_ptr_dec;
  logic             w_full;
  logic             w_empty;
  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign w_full    = r_level == (PTR_W+1)'(DEPTH);
  assign w_empty   = r_level == '0;
  assign pop_data  = r_mem[w_ptr_dec];
  assign level     = r_level;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_level <= '0;
    end else if (push) begin
      r_ptr   <= r_ptr + PTR_W'(1);
      r_level <= w_full ? r_level : r_level + (PTR_W+1)'(1);
    end else if (pop) begin
      r_ptr   <= w_ptr_dec;
      r_level <= w_empty ? r_level : r_level - (PTR_W+1)'(1);
    end
  end
  // entries survive reset; only the pointer and level are cleared
  always_ff @(posedge clk) begin
    if (push && !rst) r_mem[r_ptr] <= push_data;
  end
`ifdef PIC_STACK_STATUS_EN
  logic r_ovf;
  logic r_unf;
  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (push && w_full) || (r_ovf && !stk_flag_clr);
      r_unf <= (pop && !push && w_empty) || (r_unf && !stk_flag_clr);
    end
  end
`endif
endmodule

// File: rtl/pic_pc_stack_unit.sv
// pic_pc_stack_unit: PC, PCLATH and return stack for the midrange PIC core.
// PIC_STACK_STATUS_EN exposes sticky stack overflow/underflow flags.
module pic_pc_stack_unit
  import pic_pc_stack_unit_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int J_W        = J_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RST_VECTOR = RST_VECTOR_DEF,
  parameter int IRQ_VECTOR = IRQ_VECTOR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_incr_en,
  input  logic                   pc_j_en,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic                   irq_en,
  input  logic [J_W-1:0]         pc_j_addr,
  input  logic                   pcl_wr_en,
  input  logic [7:0]             pcl_in,
  input  logic                   pclath_wr_en,
  input  logic [PC_W-9:0]        pclath_in,
`ifdef PIC_STACK_STATUS_EN
  input  logic                   stk_flag_clr,
  output logic                   stk_ovf,
  output logic                   stk_unf,
`endif
  output logic [PC_W-1:0]        pc_out,
  output logic [7:0]             pcl_out,
  output logic [PC_W-9:0]        pclath_out,
  output logic [$clog2(DEPTH):0] stk_level
);
  logic [PC_W-1:0] r_pc;
  logic [PC_W-9:0] r_pclath;
  cmd_e            w_cmd;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_jt;
  logic [PC_W-1:0] w_pop_data;
  logic [PC_W-1:0] w_pc_nxt;
  assign w_cmd    = cmd_sel(irq_en, ret_en, call_en, pc_j_en, pcl_wr_en, pc_incr_en);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_jt     = {r_pclath[PC_W-9:J_W-8], pc_j_addr};
  always_comb begin
    w_pc_nxt = w_cmd == CMD_IRQ  ? PC_W'(IRQ_VECTOR) :
               w_cmd == CMD_RET  ? w_pop_data :
               (w_cmd == CMD_CALL || w_cmd == CMD_JMP) ? w_jt :
               w_cmd == CMD_PCL  ? {r_pclath, pcl_in} :
               w_cmd == CMD_INCR ? w_pc_inc : r_pc;
  end
  // PCLATH updates alongside any PC command; the mux above sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= PC_W'(RST_VECTOR);
      r_pclath <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (pclath_wr_en) r_pclath <= pclath_in;
    end
  end
  assign pc_out     = r_pc;
  assign pcl_out    = r_pc[7:0];
  assign pclath_out = r_pclath;
  pic_pc_stack_unit_return_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk          (clk),
    .rst          (rst),
    .push         (w_cmd == CMD_IRQ || w_cmd == CMD_CALL),
    .pop          (w_cmd == CMD_RET),
    .push_data    (w_cmd == CMD_IRQ ? r_pc : w_pc_inc),
    .pop_data     (w_pop_data),
`ifdef PIC_STACK_STATUS_EN
    .stk_flag_clr (stk_flag_clr),
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf),
`endif
    .level        (stk_level)
  );
endmodule

// File: tb/tb_pic_pc_stack_unit.sv
// tb_pic_pc_stack_unit: scoreboard bench with a behavioural PC/stack model, directed then random stimulus.
module tb_pic_pc_stack_unit;
  localparam int PC_W = 13, J_W = 11, DEPTH = 8;
  localparam int PC_MASK = (1 << PC_W) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic pc_incr_en = 0, pc_j_en = 0, call_en = 0, ret_en = 0, irq_en = 0;
  logic [J_W-1:0] pc_j_addr = '0;
  logic pcl_wr_en = 0, pclath_wr_en = 0, stk_flag_clr = 0;
  logic [7:0] pcl_in = '0;
  logic [PC_W-9:0] pclath_in = '0;
  logic [PC_W-1:0] pc_out;
  logic [7:0] pcl_out;
  logic [PC_W-9:0] pclath_out;
  logic [$clog2(DEPTH):0] stk_level;
`ifdef PIC_STACK_STATUS_EN
  logic stk_ovf, stk_unf;
`endif
  pic_pc_stack_unit dut (
    .clk(clk), .rst(rst), .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en), .call_en(call_en),
    .ret_en(ret_en), .irq_en(irq_en), .pc_j_addr(pc_j_addr), .pcl_wr_en(pcl_wr_en),
    .pcl_in(pcl_in), .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in),
`ifdef PIC_STACK_STATUS_EN
    .stk_flag_clr(stk_flag_clr), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
`endif
    .pc_out(pc_out), .pcl_out(pcl_out), .pclath_out(pclath_out), .stk_level(stk_level)
  );
  always #5 clk = ~clk;
  typedef struct { int pc; int pclath; int level; bit ovf; bit unf; } exp_t;
  exp_t q[$];
  int m_pc, m_pclath, m_level, m_ptr;
  int m_mem[DEPTH];
  bit m_ovf, m_unf;
  int vectors = 0, miscompares = 0;
  function automatic void chk(string name, int act, int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction
  function automatic void m_push(int v);
    m_mem[m_ptr] = v;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_level == DEPTH) m_ovf = 1; else m_level++;
  endfunction
  function automatic int m_pop();
    m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
    if (m_level == 0) m_unf = 1; else m_level--;
    return m_mem[m_ptr];
  endfunction
  task automatic step(input bit r, input bit irq, input bit ret, input bit call, input bit j,
                      input int a, input bit pw, input int pi, input bit lw, input int li,
                      input bit inc, input bit clr);
    exp_t e;
    @(negedge clk);
    rst = r; irq_en = irq; ret_en = ret; call_en = call; pc_j_en = j;
    pc_j_addr = J_W'(a); pcl_wr_en = pw; pcl_in = 8'(pi); pclath_wr_en = lw;
    pclath_in = (PC_W-8)'(li); pc_incr_en = inc; stk_flag_clr = clr;
    if (r) begin
      m_pc = 0; m_pclath = 0; m_level = 0; m_ptr = 0; m_ovf = 0; m_unf = 0;
    end else begin
      int old_lath, jt;
      old_lath = m_pclath;
      jt = ((old_lath >> (J_W - 8)) << J_W) | a;
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (irq) begin m_push(m_pc); m_pc = 4; end
      else if (ret) m_pc = m_pop();
      else if (call) begin m_push((m_pc + 1) & PC_MASK); m_pc = jt; end
      else if (j) m_pc = jt;
      else if (pw) m_pc = (old_lath << 8) | pi;
      else if (inc) m_pc = (m_pc + 1) & PC_MASK;
      if (lw) m_pclath = li;
    end
    e.pc = m_pc; e.pclath = m_pclath; e.level = m_level; e.ovf = m_ovf; e.unf = m_unf;
    q.push_back(e);
  endtask
  task automatic nop();            step(0,0,0,0,0,0,0,0,0,0,0,0); endtask
  task automatic incr();           step(0,0,0,0,0,0,0,0,0,0,1,0); endtask
  task automatic lath(input int v); step(0,0,0,0,0,0,0,0,1,v,0,0); endtask
  task automatic pcl(input int v);  step(0,0,0,0,0,0,1,v,0,0,0,0); endtask
  task automatic call(input int a); step(0,0,0,1,0,a,0,0,0,0,0,0); endtask
  task automatic ret();            step(0,0,1,0,0,0,0,0,0,0,0,0); endtask
  // monitor: outputs are valid every cycle, so each pending expectation is retired one edge later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk("pc_out", int'(pc_out), e.pc);
        chk("pcl_out", int'(pcl_out), e.pc & 8'hff);
        chk("pclath_out", int'(pclath_out), e.pclath);
        chk("stk_level", int'(stk_level), e.level);
`ifdef PIC_STACK_STATUS_EN
        chk("stk_ovf", int'(stk_ovf), int'(e.ovf));
        chk("stk_unf", int'(stk_unf), int'(e.unf));
`endif
      end
    end
  end
  initial begin
    step(1,0,0,0,0,0,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,0,0,1,0);
    repeat (3) incr();
    lath(8'h18);
    step(0,0,0,0,1,12'h123,0,0,0,0,0,0);
    lath(0);
    pcl(8'h50);
    call(12'h200);
    ret();
    for (int i = 0; i < 9; i++) call(12'h100 + 16 * i);
    for (int i = 0; i < 8; i++) ret();
    ret();
    step(0,0,0,0,0,0,0,0,0,0,0,1);
    lath(1);
    pcl(8'h23);
    step(0,1,1,0,0,0,0,0,0,0,0,0);
    ret();
    lath(2);
    step(0,0,0,0,0,0,1,8'h80,1,5,0,0);
    step(0,0,0,1,1,12'h7ff,1,8'hff,0,0,1,0);
    pcl(8'hff); lath(31); pcl(8'hff); incr();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, int'($urandom_range(0, 2047)),
           $urandom_range(0, 5) == 0, int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    nop();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
